// File: rtl/capture_pkg.sv
// Shared types and constants for the capture scheduler: FSM states,
// packet-length lookup and the two supported path counts.
package capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_PKT,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int CNT_W    = 9;
  localparam int PATHS_48 = 48;
  localparam int PATHS_96 = 96;

  function automatic logic [CNT_W-1:0] len_words(input logic [1:0] code);
    case (code)
      2'd0:    return 9'd32;
      2'd1:    return 9'd64;
      2'd2:    return 9'd128;
      default: return 9'd256;
    endcase
  endfunction

endpackage

// File: rtl/capture_sched_rd_port_arb.sv
// Shared memory read-port arbiter: packet reads always win, a single merged
// MDIO request is served in the first cycle the packet engine leaves the port free.
module rd_port_arb
  #(parameter int ADDR_W = 15,
    parameter int PATH_W = 7)
  (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_rd_req,
    input  logic [ADDR_W-1:0] pkt_rd_addr,
    input  logic [PATH_W-1:0] pkt_rd_path,
    input  logic              mdio_req,
    input  logic [PATH_W-1:0] mdio_path_sel,
    input  logic [ADDR_W-1:0] mdio_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [PATH_W-1:0] mem_rd_path_sel,
    output logic              mdio_rd_valid
  );

  logic              pending_q, pending_d;
  logic              grant_q, grant_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [PATH_W-1:0] rd_sel_q, rd_sel_d;
  logic              mdio_valid_q, mdio_valid_d;

  // A pulse arriving while a request is pending is absorbed into it.
  always_comb begin
    grant_d      = pending_q & ~pkt_rd_req;
    pending_d    = pending_q ? ~grant_d : mdio_req;
    rd_en_d      = pkt_rd_req | grant_d;
    rd_addr_d    = '0;
    rd_sel_d     = '0;
    mdio_valid_d = grant_q;
    if (pkt_rd_req) begin
      rd_addr_d = pkt_rd_addr;
      rd_sel_d  = pkt_rd_path;
    end else if (grant_d) begin
      rd_addr_d = mdio_addr;
      rd_sel_d  = mdio_path_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= 1'b0;
      grant_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_sel_q     <= '0;
      mdio_valid_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      grant_q      <= grant_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      rd_sel_q     <= rd_sel_d;
      mdio_valid_q <= mdio_valid_d;
    end
  end

  assign mem_rd_en       = rd_en_q;
  assign mem_rd_addr     = rd_addr_q;
  assign mem_rd_path_sel = rd_sel_q;
  assign mdio_rd_valid   = mdio_valid_q;

endmodule

// File: rtl/capture_sched.sv
// Capture scheduler: captures L words, then streams L words per path for N paths
// with optional idle gaps, sharing the memory read port with MDIO readback.
module capture_sched
  import capture_pkg::*;
  #(parameter int ADDR_W = 15,
    parameter int PATH_W = 7)
  (
    input  logic              clk_200m,
    input  logic              rst_200m,
    input  logic              rf_capture_start,
    input  logic              rf_capture_again,
    input  logic              rf_capture_mode,
    input  logic              rf_96path_en,
    input  logic [1:0]        rf_pkt_data_length,
    input  logic [15:0]       rf_pkt_idle_length,
    input  logic              rf_mdio_read_pulse,
    input  logic [PATH_W-1:0] rf_mdio_data_sel,
    input  logic [ADDR_W-1:0] rf_mdio_memory_addr,
    output logic              cap_wr_en,
    output logic [ADDR_W-1:0] cap_wr_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [PATH_W-1:0] mem_rd_path_sel,
    output logic              pkt_valid,
    output logic              pkt_sop,
    output logic              pkt_eop,
    output logic [PATH_W-1:0] pkt_path,
    output logic              mdio_read_pulse_r,
    output logic              capture_busy,
    output logic              capture_done
  );

  state_t            state_q, state_d;
  logic              start_prev_q, start_prev_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [PATH_W-1:0] path_cnt_q, path_cnt_d;
  logic [15:0]       gap_cnt_q, gap_cnt_d;
  logic              n96_q, n96_d;
  logic [1:0]        len_code_q, len_code_d;
  logic [15:0]       idle_len_q, idle_len_d;

  logic              cap_wr_en_q, cap_wr_en_d;
  logic [ADDR_W-1:0] cap_wr_addr_q, cap_wr_addr_d;
  logic              pkt_rd_q, pkt_rd_d;
  logic              pkt_word0_q, pkt_word0_d;
  logic              pkt_last_q, pkt_last_d;
  logic [PATH_W-1:0] pkt_rd_path_q, pkt_rd_path_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic              pkt_sop_q, pkt_sop_d;
  logic              pkt_eop_q, pkt_eop_d;
  logic [PATH_W-1:0] pkt_path_q, pkt_path_d;
  logic              capture_busy_q, capture_busy_d;
  logic              capture_done_q, capture_done_d;

  logic              restart;
  logic [CNT_W-1:0]  len_last;
  logic [PATH_W-1:0] path_last;

  assign len_last  = len_words(len_code_q) - CNT_W'(1);
  assign path_last = n96_q ? PATH_W'(PATHS_96 - 1) : PATH_W'(PATHS_48 - 1);

  always_comb begin
    state_d      = state_q;
    start_prev_d = rf_capture_start;
    word_cnt_d   = word_cnt_q;
    path_cnt_d   = path_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    n96_d        = n96_q;
    len_code_d   = len_code_q;
    idle_len_d   = idle_len_q;
    restart      = 1'b0;

    if (!rf_capture_start) begin
      state_d    = ST_IDLE;
      word_cnt_d = '0;
      path_cnt_d = '0;
      gap_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: restart = ~start_prev_q;
        ST_CAPTURE: begin
          if (word_cnt_q == len_last) begin
            word_cnt_d = '0;
            path_cnt_d = '0;
            state_d    = ST_PKT;
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end
        ST_PKT: begin
          if (word_cnt_q == len_last) begin
            word_cnt_d = '0;
            if (idle_len_q != 16'd0) begin
              gap_cnt_d = '0;
              state_d   = ST_GAP;
            end else if (path_cnt_q == path_last) begin
              state_d = ST_DONE;
            end else begin
              path_cnt_d = path_cnt_q + PATH_W'(1);
            end
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == idle_len_q - 16'd1) begin
            gap_cnt_d = '0;
            if (path_cnt_q == path_last) begin
              state_d = ST_DONE;
            end else begin
              path_cnt_d = path_cnt_q + PATH_W'(1);
              state_d    = ST_PKT;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 16'd1;
          end
        end
        ST_DONE: restart = rf_capture_again | rf_capture_mode;
        default: state_d = ST_IDLE;
      endcase

      // Configuration is sampled only here, so mid-run register writes are ignored.
      if (restart) begin
        n96_d      = rf_96path_en;
        len_code_d = rf_pkt_data_length;
        idle_len_d = rf_pkt_idle_length;
        word_cnt_d = '0;
        path_cnt_d = '0;
        gap_cnt_d  = '0;
        state_d    = ST_CAPTURE;
      end
    end
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_comb begin
    cap_wr_en_d    = (state_d == ST_CAPTURE);
    cap_wr_addr_d  = cap_wr_en_d ? ADDR_W'(word_cnt_d) : '0;
    pkt_rd_d       = (state_d == ST_PKT);
    pkt_word0_d    = pkt_rd_d && (word_cnt_d == '0);
    pkt_last_d     = pkt_rd_d && (word_cnt_d == len_last);
    pkt_rd_path_d  = pkt_rd_d ? path_cnt_d : '0;
    pkt_valid_d    = pkt_rd_q;
    pkt_sop_d      = pkt_word0_q;
    pkt_eop_d      = pkt_last_q & rf_capture_start;
    pkt_path_d     = pkt_rd_path_q;
    capture_busy_d = (state_d inside {ST_CAPTURE, ST_PKT, ST_GAP});
    capture_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_200m) begin
    if (rst_200m) begin
      state_q        <= ST_IDLE;
      start_prev_q   <= 1'b0;
      word_cnt_q     <= '0;
      path_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      n96_q          <= 1'b0;
      len_code_q     <= '0;
      idle_len_q     <= '0;
      cap_wr_en_q    <= 1'b0;
      cap_wr_addr_q  <= '0;
      pkt_rd_q       <= 1'b0;
      pkt_word0_q    <= 1'b0;
      pkt_last_q     <= 1'b0;
      pkt_rd_path_q  <= '0;
      pkt_valid_q    <= 1'b0;
      pkt_sop_q      <= 1'b0;
      pkt_eop_q      <= 1'b0;
      pkt_path_q     <= '0;
      capture_busy_q <= 1'b0;
      capture_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_prev_q   <= start_prev_d;
      word_cnt_q     <= word_cnt_d;
      path_cnt_q     <= path_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      n96_q          <= n96_d;
      len_code_q     <= len_code_d;
      idle_len_q     <= idle_len_d;
      cap_wr_en_q    <= cap_wr_en_d;
      cap_wr_addr_q  <= cap_wr_addr_d;
      pkt_rd_q       <= pkt_rd_d;
      pkt_word0_q    <= pkt_word0_d;
      pkt_last_q     <= pkt_last_d;
      pkt_rd_path_q  <= pkt_rd_path_d;
      pkt_valid_q    <= pkt_valid_d;
      pkt_sop_q      <= pkt_sop_d;
      pkt_eop_q      <= pkt_eop_d;
      pkt_path_q     <= pkt_path_d;
      capture_busy_q <= capture_busy_d;
      capture_done_q <= capture_done_d;
    end
  end

  rd_port_arb #(.ADDR_W(ADDR_W), .PATH_W(PATH_W)) u_rd_port_arb (
    .clk             (clk_200m),
    .rst             (rst_200m),
    .pkt_rd_req      (pkt_rd_d),
    .pkt_rd_addr     (ADDR_W'(word_cnt_d)),
    .pkt_rd_path     (pkt_rd_path_d),
    .mdio_req        (rf_mdio_read_pulse),
    .mdio_path_sel   (rf_mdio_data_sel),
    .mdio_addr       (rf_mdio_memory_addr),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_path_sel (mem_rd_path_sel),
    .mdio_rd_valid   (mdio_read_pulse_r)
  );

  assign cap_wr_en    = cap_wr_en_q;
  assign cap_wr_addr  = cap_wr_addr_q;
  assign pkt_valid    = pkt_valid_q;
  assign pkt_sop      = pkt_sop_q;
  assign pkt_eop      = pkt_eop_q;
  assign pkt_path     = pkt_path_q;
  assign capture_busy = capture_busy_q;
  assign capture_done = capture_done_q;

endmodule
